// File: rtl/comparator_pkg.sv
// Shared types and constants for the registered magnitude comparator.
// The cascade flags travel between 4-bit slices as a packed {gt, eq, lt} triple.
package comparator_pkg;

  localparam int SLICE_W = 4;

  typedef struct packed {
    logic gt;
    logic eq;
    logic lt;
  } cmp_flags_t;

  // Register value meaning "no result yet"; seen only in and right after reset.
  localparam cmp_flags_t CMP_RESET   = 3'b000;
  // Seed for the most significant slice: nothing above it has decided yet.
  localparam cmp_flags_t CMP_EQ_SEED = 3'b010;

  // Local 4-bit magnitude decision, ignoring any cascade input.
  function automatic cmp_flags_t cmp_nibble(input logic [SLICE_W-1:0] x,
                                            input logic [SLICE_W-1:0] y);
    cmp_flags_t f;
    f.gt = (x > y);
    f.lt = (x < y);
    f.eq = (x == y);
    return f;
  endfunction

endpackage

// File: rtl/comparator_16bit_slice.sv
// comparator_slice_4b: combinational 4-bit magnitude compare with cascade in/out.
// Slices are chained MSB-first: a more significant slice that has already found
// an inequality wins, and this slice only decides while everything above is equal.
module comparator_slice_4b
  import comparator_pkg::*;
(
  input  logic [SLICE_W-1:0] a,
  input  logic [SLICE_W-1:0] b,
  input  logic               gt_in,
  input  logic               eq_in,
  input  logic               lt_in,
  output logic               gt_out,
  output logic               eq_out,
  output logic               lt_out
);

  cmp_flags_t w_local;
  cmp_flags_t w_casc_in;
  cmp_flags_t w_result;

  assign w_local   = cmp_nibble(a, b);
  assign w_casc_in = '{gt: gt_in, eq: eq_in, lt: lt_in};

  // Pass an upstream decision through untouched; otherwise use this nibble.
  always_comb begin
    w_result = w_casc_in;
    if (w_casc_in.eq) begin
      w_result = w_local;
    end
  end

  assign gt_out = w_result.gt;
  assign eq_out = w_result.eq;
  assign lt_out = w_result.lt;

endmodule

// File: rtl/comparator_16bit.sv
// comparator_16bit: registered WIDTH-bit magnitude comparator, one cycle latency.
// Built from WIDTH/4 cascaded 4-bit slices evaluated MSB-first, followed by a
// single flag register. WIDTH must be a positive multiple of 4.
// Optional build macro COMPARATOR_SIGNED_EN adds the sgn input; with sgn=1 the
// operands are two's complement, handled by inverting both sign bits ahead of
// the MSB slice (this maps signed order onto unsigned order).
module comparator_16bit
  import comparator_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  output logic             great,
  output logic             equal,
  output logic             less,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b
`ifdef COMPARATOR_SIGNED_EN
  ,
  input  logic             sgn
`endif
);

  localparam int NSLICE = WIDTH / SLICE_W;

  logic [WIDTH-1:0] w_a_adj;
  logic [WIDTH-1:0] w_b_adj;
  cmp_flags_t       w_casc [NSLICE+1];
  cmp_flags_t       r_flags;

`ifdef COMPARATOR_SIGNED_EN
  assign w_a_adj = {a[WIDTH-1] ^ sgn, a[WIDTH-2:0]};
  assign w_b_adj = {b[WIDTH-1] ^ sgn, b[WIDTH-2:0]};
`else
  assign w_a_adj = a;
  assign w_b_adj = b;
`endif

  // Chain index NSLICE is the seed above the top slice; index 0 is the result.
  assign w_casc[NSLICE] = CMP_EQ_SEED;

  for (genvar i = NSLICE - 1; i >= 0; i--) begin : g_slice
    comparator_slice_4b u_slice (
      .a      (w_a_adj[i*SLICE_W +: SLICE_W]),
      .b      (w_b_adj[i*SLICE_W +: SLICE_W]),
      .gt_in  (w_casc[i+1].gt),
      .eq_in  (w_casc[i+1].eq),
      .lt_in  (w_casc[i+1].lt),
      .gt_out (w_casc[i].gt),
      .eq_out (w_casc[i].eq),
      .lt_out (w_casc[i].lt)
    );
  end

  // Capture the cascade result each cycle; reset clears to "no result yet".
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_flags <= CMP_RESET;
    end else begin
      r_flags <= w_casc[0];
    end
  end

  assign great = r_flags.gt;
  assign equal = r_flags.eq;
  assign less  = r_flags.lt;

endmodule

// File: tb/tb_comparator_16bit.sv
// Self-checking bench for comparator_16bit: directed vectors, hand-computed flags.
// Signed-mode vectors are included when COMPARATOR_SIGNED_EN is defined.
module tb_comparator_16bit;

  logic        clk;
  logic        rst;
  logic        great;
  logic        equal;
  logic        less;
  logic [15:0] a;
  logic [15:0] b;
`ifdef COMPARATOR_SIGNED_EN
  logic        sgn;
`endif

  int checks;
  int errors;

  comparator_16bit #(.WIDTH(16)) dut (
    .clk   (clk),
    .rst   (rst),
    .great (great),
    .equal (equal),
    .less  (less),
    .a     (a),
    .b     (b)
`ifdef COMPARATOR_SIGNED_EN
    ,
    .sgn   (sgn)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive operands at the falling edge, then sample just after the next rising edge.
  task automatic apply(input logic [15:0] va, input logic [15:0] vb);
    @(negedge clk);
    a = va;
    b = vb;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #2;
    checks++;
    if ({great, equal, less} !== 3'b000) begin
      errors++;
      $display("FAIL reset_async: got %b want 000", {great, equal, less});
    end
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checks++;
      if ({great, equal, less} !== 3'b000) begin
        errors++;
        $display("FAIL reset_hold_%0d: got %b want 000", i, {great, equal, less});
      end
    end
    a = 16'h0000;
    b = 16'h0000;
    rst = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if ({great, equal, less} !== 3'b010) begin
      errors++;
      $display("FAIL reset_first_cmp: got %b want 010", {great, equal, less});
    end
  endtask

  task automatic test_unsigned();
    logic [15:0] va [3];
    logic [15:0] vb [3];
    logic [2:0]  exp [3];
    logic [2:0]  prev;
    va[0] = 16'd60000; vb[0] = 16'd60000; exp[0] = 3'b010;
    va[1] = 16'd5000;  vb[1] = 16'd4001;  exp[1] = 3'b100;
    va[2] = 16'd2;     vb[2] = 16'd4;     exp[2] = 3'b001;
    prev = 3'b010;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      a = va[i];
      b = vb[i];
      #1;
      checks++;
      if ({great, equal, less} !== prev) begin
        errors++;
        $display("FAIL latency_hold_%0d: got %b want %b", i, {great, equal, less}, prev);
      end
      @(posedge clk);
      #1;
      checks++;
      if ({great, equal, less} !== exp[i]) begin
        errors++;
        $display("FAIL unsigned_%0d a=%h b=%h: got %b want %b", i, va[i], vb[i],
                 {great, equal, less}, exp[i]);
      end
      prev = exp[i];
    end
  endtask

  task automatic test_boundaries();
    apply(16'hFFFF, 16'h0000);
    checks++;
    if ({great, equal, less} !== 3'b100) begin
      errors++;
      $display("FAIL bound_ffff_0000: got %b want 100", {great, equal, less});
    end
    apply(16'h0000, 16'hFFFF);
    checks++;
    if ({great, equal, less} !== 3'b001) begin
      errors++;
      $display("FAIL bound_0000_ffff: got %b want 001", {great, equal, less});
    end
    apply(16'h8000, 16'h7FFF);
    checks++;
    if ({great, equal, less} !== 3'b100) begin
      errors++;
      $display("FAIL bound_8000_7fff: got %b want 100", {great, equal, less});
    end
  endtask

  task automatic test_slices();
    apply(16'h1234, 16'h1235);
    checks++;
    if ({great, equal, less} !== 3'b001) begin
      errors++;
      $display("FAIL slice_lsb: got %b want 001", {great, equal, less});
    end
    apply(16'h2000, 16'h1FFF);
    checks++;
    if ({great, equal, less} !== 3'b100) begin
      errors++;
      $display("FAIL slice_msb: got %b want 100", {great, equal, less});
    end
    apply(16'h0A00, 16'h0B00);
    checks++;
    if ({great, equal, less} !== 3'b001) begin
      errors++;
      $display("FAIL slice_mid: got %b want 001", {great, equal, less});
    end
    apply(16'h0070, 16'h006F);
    checks++;
    if ({great, equal, less} !== 3'b100) begin
      errors++;
      $display("FAIL slice_second: got %b want 100", {great, equal, less});
    end
  endtask

  task automatic test_reset_mid();
    apply(16'd5, 16'd3);
    checks++;
    if ({great, equal, less} !== 3'b100) begin
      errors++;
      $display("FAIL mid_pre: got %b want 100", {great, equal, less});
    end
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if ({great, equal, less} !== 3'b000) begin
      errors++;
      $display("FAIL mid_async_clear: got %b want 000", {great, equal, less});
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++;
    if ({great, equal, less} !== 3'b000) begin
      errors++;
      $display("FAIL mid_released_pre_edge: got %b want 000", {great, equal, less});
    end
    @(posedge clk);
    #1;
    checks++;
    if ({great, equal, less} !== 3'b100) begin
      errors++;
      $display("FAIL mid_recover: got %b want 100", {great, equal, less});
    end
  endtask

`ifdef COMPARATOR_SIGNED_EN
  task automatic test_signed();
    sgn = 1'b1;
    apply(16'hFFFF, 16'h0001);
    checks++;
    if ({great, equal, less} !== 3'b001) begin
      errors++;
      $display("FAIL signed_m1_p1: got %b want 001", {great, equal, less});
    end
    sgn = 1'b0;
    apply(16'hFFFF, 16'h0001);
    checks++;
    if ({great, equal, less} !== 3'b100) begin
      errors++;
      $display("FAIL unsigned_ffff_0001: got %b want 100", {great, equal, less});
    end
    sgn = 1'b1;
    apply(16'h8000, 16'h7FFF);
    checks++;
    if ({great, equal, less} !== 3'b001) begin
      errors++;
      $display("FAIL signed_min_max: got %b want 001", {great, equal, less});
    end
    apply(16'hFFFE, 16'hFFFE);
    checks++;
    if ({great, equal, less} !== 3'b010) begin
      errors++;
      $display("FAIL signed_equal: got %b want 010", {great, equal, less});
    end
    sgn = 1'b0;
  endtask
`endif

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b0;
    a = 16'h0000;
    b = 16'h0000;
`ifdef COMPARATOR_SIGNED_EN
    sgn = 1'b0;
`endif
    #1;
    test_reset();
    test_unsigned();
    test_boundaries();
    test_slices();
    test_reset_mid();
`ifdef COMPARATOR_SIGNED_EN
    test_signed();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
